// File: rtl/button_conditioner.sv
// Button conditioner: per-button synchroniser and debounce, press detection,
// auto-repeat on the move buttons, and a one-pulse-per-cycle command arbiter.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_RATE     = 3750000,
    parameter int unsigned CNT_W           = 24
) (
    input  logic       clk_25MHz,
    input  logic       rst_n,
    input  logic       btn_right_raw,
    input  logic       btn_left_raw,
    input  logic       btn_drop_raw,
    output logic       move_right,
    output logic       move_left,
    output logic       drop_piece,
    output logic [2:0] btn_state
);

    localparam int unsigned      NUM_BTN = 3;
    localparam int unsigned      NUM_REP = 2;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    // Channel order everywhere: bit 0 right, bit 1 left, bit 2 drop
    logic [NUM_BTN-1:0] raw_c;
    logic [NUM_BTN-1:0] sync_meta;
    logic [NUM_BTN-1:0] sync_q;
    logic [NUM_BTN-1:0] stable;
    logic [NUM_BTN-1:0] stable_d;
    logic [NUM_BTN-1:0] press_c;
    logic [NUM_REP-1:0] rep_req_c;
    logic               both_held_c;
    logic               req_drop_c;
    logic               req_right_c;
    logic               req_left_c;

    assign raw_c       = {btn_drop_raw, btn_left_raw, btn_right_raw};
    assign press_c     = stable & ~stable_d;
    assign both_held_c = stable[0] & stable[1];
    assign btn_state   = stable;

    // Two-flop synchroniser plus a delayed copy of the stable levels for edge detection
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync_q    <= '0;
            stable_d  <= '0;
        end else begin
            sync_meta <= raw_c;
            sync_q    <= sync_meta;
            stable_d  <= stable;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_debounce
        logic [CNT_W-1:0] dcnt;
        logic             level;

        // Flip the stable level only after DEBOUNCE_CYCLES consecutive disagreeing samples
        always_ff @(posedge clk_25MHz or negedge rst_n) begin
            if (!rst_n) begin
                dcnt  <= '0;
                level <= 1'b0;
            end else if (sync_q[i] == level) begin
                dcnt <= '0;
            end else if (dcnt == DB_LAST) begin
                level <= ~level;
                dcnt  <= '0;
            end else begin
                dcnt <= dcnt + CNT_ONE;
            end
        end

        assign stable[i] = level;
    end

    for (genvar i = 0; i < NUM_REP; i++) begin : g_repeat
        rep_state_t       state_q;
        rep_state_t       state_d;
        logic [CNT_W-1:0] rcnt_q;
        logic [CNT_W-1:0] rcnt_d;
        logic             req_c;

        // Auto-repeat state and interval counter
        always_ff @(posedge clk_25MHz or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                rcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                rcnt_q  <= rcnt_d;
            end
        end

        // Release or a left+right chord kills the repeat; otherwise count out the intervals
        always_comb begin
            state_d = state_q;
            rcnt_d  = rcnt_q;
            req_c   = 1'b0;
            if (!stable[i] || both_held_c) begin
                state_d = IDLE;
                rcnt_d  = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (press_c[i]) begin
                            state_d = DELAY;
                            rcnt_d  = '0;
                        end
                    end
                    DELAY: begin
                        if (rcnt_q == RD_LAST) begin
                            req_c   = 1'b1;
                            rcnt_d  = '0;
                            state_d = REPEAT;
                        end else begin
                            rcnt_d = rcnt_q + CNT_ONE;
                        end
                    end
                    REPEAT: begin
                        if (rcnt_q == RR_LAST) begin
                            req_c  = 1'b1;
                            rcnt_d = '0;
                        end else begin
                            rcnt_d = rcnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        rcnt_d  = '0;
                    end
                endcase
            end
        end

        assign rep_req_c[i] = req_c;
    end

    // Simultaneous left/right presses cancel each other; repeats are already chord-gated
    always_comb begin
        req_drop_c  = press_c[2];
        req_right_c = (press_c[0] & ~press_c[1]) | rep_req_c[0];
        req_left_c  = (press_c[1] & ~press_c[0]) | rep_req_c[1];
    end

    // Registered command pulses, drop > right > left, losers dropped
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            drop_piece <= 1'b0;
            move_right <= 1'b0;
            move_left  <= 1'b0;
        end else begin
            drop_piece <= req_drop_c;
            move_right <= ~req_drop_c & req_right_c;
            move_left  <= ~req_drop_c & ~req_right_c & req_left_c;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button activity,
// checked against a sample-window / event-schedule reference model.
module tb_button_conditioner;

    localparam int unsigned D  = 4;
    localparam int unsigned RD = 10;
    localparam int unsigned RR = 5;
    localparam int unsigned CW = 8;

    typedef struct packed {
        int unsigned edge_n;
        logic [2:0]  v;
    } item_t;

    logic       clk;
    logic       rst_n;
    logic       btn_right_raw;
    logic       btn_left_raw;
    logic       btn_drop_raw;
    logic       move_right;
    logic       move_left;
    logic       drop_piece;
    logic [2:0] btn_state;

    int unsigned cyc   = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    item_t sq[$];
    item_t pq[$];
    item_t plog[$];

    // Reference model state
    logic [2:0]  rq[$];
    logic [2:0]  m_stable;
    logic [2:0]  m_pend;
    logic [1:0]  m_alive;
    int unsigned m_next[2];

    // Monitor scratch
    item_t      mit;
    logic [2:0] act;
    logic [2:0] exp_p;

    int unsigned offs[7] = '{1, 11, 16, 21, 26, 31, 36};

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR),
        .CNT_W          (CW)
    ) dut (
        .clk_25MHz    (clk),
        .rst_n        (rst_n),
        .btn_right_raw(btn_right_raw),
        .btn_left_raw (btn_left_raw),
        .btn_drop_raw (btn_drop_raw),
        .move_right   (move_right),
        .move_left    (move_left),
        .drop_piece   (drop_piece),
        .btn_state    (btn_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got 'h%0h, want 'h%0h", name, cyc, a, e);
        end
    endtask

    function automatic void model_reset();
        rq.delete();
        for (int i = 0; i < int'(D) + 2; i++) rq.push_back(3'b000);
        m_stable  = 3'b000;
        m_pend    = 3'b000;
        m_alive   = 2'b00;
        m_next[0] = 0;
        m_next[1] = 0;
        sq.delete();
        pq.delete();
    endfunction

    // Model one clock edge e with raw sample v. A stable level flips when the
    // synced samples seen by the last D edges (raw from 2..D+1 edges back) all
    // disagree with it. Move buttons schedule repeats at fixed offsets from the
    // press while held alone.
    function automatic void model_edge(input logic [2:0] v, input int unsigned e);
        logic [2:0] nxt;
        logic [2:0] press;
        logic [1:0] rep;
        logic       all_diff;
        logic       both;
        logic       r_req;
        logic       l_req;
        item_t      it;
        rq.push_back(v);
        void'(rq.pop_front());
        nxt = m_stable;
        for (int ch = 0; ch < 3; ch++) begin
            all_diff = 1'b1;
            for (int k = 0; k < int'(D); k++)
                if (rq[rq.size() - 3 - k][ch] == m_stable[ch]) all_diff = 1'b0;
            if (all_diff) nxt[ch] = ~m_stable[ch];
        end
        press    = nxt & ~m_stable;
        m_stable = nxt;
        it.edge_n = e;
        it.v      = m_stable;
        sq.push_back(it);
        if (m_pend != 3'b000) begin
            it.v = m_pend;
            pq.push_back(it);
        end
        both = m_stable[0] & m_stable[1];
        rep  = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            if (!m_stable[ch] || both) begin
                m_alive[ch] = 1'b0;
            end else if (press[ch]) begin
                m_alive[ch] = 1'b1;
                m_next[ch]  = e + 1 + RD;
            end
            if (m_alive[ch] && m_next[ch] == e + 1) begin
                rep[ch]    = 1'b1;
                m_next[ch] = m_next[ch] + RR;
            end
        end
        r_req = (press[0] & ~press[1]) | rep[0];
        l_req = (press[1] & ~press[0]) | rep[1];
        if (press[2])   m_pend = 3'b100;
        else if (r_req) m_pend = 3'b001;
        else if (l_req) m_pend = 3'b010;
        else            m_pend = 3'b000;
    endfunction

    task automatic step(input logic [2:0] v, input logic rst_val);
        @(negedge clk);
        rst_n = rst_val;
        {btn_drop_raw, btn_left_raw, btn_right_raw} = v;
        if (!rst_val) model_reset();
        else          model_edge(v, cyc + 1);
    endtask

    task automatic hold(input logic [2:0] v, input int unsigned n, output int unsigned t_first);
        t_first = 0;
        for (int unsigned i = 0; i < n; i++) begin
            step(v, 1'b1);
            if (i == 0) t_first = cyc + 1;
        end
    endtask

    function automatic int n_pulses(input int ch, input int unsigned lo, input int unsigned hi);
        int n = 0;
        foreach (plog[i])
            if (plog[i].edge_n >= lo && plog[i].edge_n <= hi && plog[i].v[ch]) n++;
        return n;
    endfunction

    // Monitor: compare each edge's outputs against the queued model responses
    initial begin
        forever begin
            @(posedge clk);
            #1;
            act = {drop_piece, move_left, move_right};
            if (!rst_n) begin
                chk("reset_pulses", 32'(act), 0);
                chk("reset_btn_state", 32'(btn_state), 0);
            end else begin
                if (act != 3'b000) begin
                    mit.edge_n = cyc;
                    mit.v      = act;
                    plog.push_back(mit);
                end
                while (sq.size() > 0 && sq[0].edge_n < cyc) void'(sq.pop_front());
                if (sq.size() > 0 && sq[0].edge_n == cyc) begin
                    mit = sq.pop_front();
                    chk("btn_state", 32'(btn_state), 32'(mit.v));
                end else begin
                    chk("state_item_edge", (sq.size() > 0) ? sq[0].edge_n : 0, cyc);
                end
                exp_p = 3'b000;
                if (pq.size() > 0 && pq[0].edge_n == cyc) begin
                    mit   = pq.pop_front();
                    exp_p = mit.v;
                end
                chk("pulses", 32'(act), 32'(exp_p));
            end
        end
    end

    // Stimulus
    initial begin
        int unsigned t0;
        int unsigned t1;
        int unsigned tf;
        logic [2:0]  v;
        int unsigned n;
        btn_right_raw = 1'b0;
        btn_left_raw  = 1'b0;
        btn_drop_raw  = 1'b0;
        rst_n         = 1'b1;
        model_reset();
        #2 rst_n = 1'b0;
        repeat (4) step(3'b000, 1'b0);
        hold(3'b000, 4, t0);

        // Clean right press
        hold(3'b001, 8, t0);
        hold(3'b000, 14, tf);
        chk("t1_right_at_edge7", n_pulses(0, t0 + 6, t0 + 6), 1);
        chk("t1_right_total", n_pulses(0, t0, cyc), 1);
        chk("t1_other_total", n_pulses(1, t0, cyc) + n_pulses(2, t0, cyc), 0);

        // Bouncy drop press
        hold(3'b100, 2, t0);
        hold(3'b000, 2, tf);
        hold(3'b100, 2, tf);
        hold(3'b000, 2, tf);
        hold(3'b100, 10, tf);
        hold(3'b000, 12, t1);
        chk("t2_drop_at_edge7", n_pulses(2, tf + 6, tf + 6), 1);
        chk("t2_drop_total", n_pulses(2, t0, cyc), 1);

        // Left auto-repeat, released mid-interval
        hold(3'b010, 38, t0);
        hold(3'b000, 25, tf);
        foreach (offs[i]) chk("t3_left_repeat", n_pulses(1, t0 + 5 + offs[i], t0 + 5 + offs[i]), 1);
        chk("t3_left_total", n_pulses(1, t0, cyc), 7);

        // Drop beats right; left+right chord is silent
        hold(3'b101, 8, t0);
        hold(3'b000, 14, tf);
        chk("t4_drop_wins", n_pulses(2, t0 + 6, t0 + 6), 1);
        chk("t4_right_lost", n_pulses(0, t0, cyc), 0);
        hold(3'b011, 30, t0);
        hold(3'b000, 12, tf);
        chk("t4_chord_silent", n_pulses(0, t0, cyc) + n_pulses(1, t0, cyc), 0);

        // Reset during repeat with left held
        hold(3'b010, 25, t0);
        repeat (3) step(3'b010, 1'b0);
        hold(3'b010, 30, t1);
        hold(3'b000, 12, tf);
        chk("t5_pre_reset_left", n_pulses(1, t0 + 6, t0 + 6), 1);
        chk("t5_quiet_after_reset", n_pulses(1, t1, t1 + 5), 0);
        chk("t5_fresh_left", n_pulses(1, t1 + 6, t1 + 6), 1);
        chk("t5_first_repeat", n_pulses(1, t1 + 16, t1 + 16), 1);

        // Short glitch
        hold(3'b001, 3, t0);
        hold(3'b000, 10, tf);
        chk("t6_glitch", n_pulses(0, t0, cyc), 0);

        // Random button activity: short glitches and long holds
        repeat (150) begin
            v = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) n = $urandom_range(1, 5);
            else                           n = $urandom_range(6, 45);
            hold(v, n, tf);
        end
        hold(3'b000, 15, tf);
        chk("pending_pulses", pq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
